alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Initiator side of the ALU operand/result interface: takes one operation request at a time over a valid/ready port and drives operands, opcode and output-enable into the combinational ALU.
- Waits a configurable settle time, then samples the ALU's tri-stated result bus and returns the result over a valid/ready response port.
- Sits between the datapath sequencer and the ALU; it is the only agent that asserts the ALU output-enable.

Parameters:
- DATA_W, 8, operand width
- RES_W, 16, result bus width
- SETTLE_CYCLES, 1, cycles output-enable is held before result capture (legal 1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_cmd  input  4  opcode (alu_pkg encoding)
- req_a  input  DATA_W  operand A
- req_b  input  DATA_W  operand B
- alu_cmd  output  4  opcode driven to ALU
- alu_a  output  DATA_W  operand A driven to ALU
- alu_b  output  DATA_W  operand B driven to ALU
- alu_oe  output  1  ALU output-enable
- alu_d  input  RES_W  ALU result bus; high-Z when alu_oe=0
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  RES_W  captured result
- rsp_cmd  output  4  opcode of this response
- rsp_err  output  1  divide-by-zero; ALU not exercised

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
- Reset values (rst_n low at an edge): state IDLE; req_ready=1, alu_oe=0, rsp_valid=0, rsp_err=0; alu_a/alu_b/alu_cmd/rsp_data/rsp_cmd all 0. Reset mid-operation drops the in-flight op with no response.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge T, register a/b/cmd onto the alu_* outputs and clear the settle counter.
    - If cmd=DIV and b=0: go to RESP with rsp_data={RES_W{1}}, rsp_err=1, rsp_cmd=cmd; alu_oe stays 0.
    - Otherwise: go to SETTLE with alu_oe=1 from cycle T+1.
  - SETTLE: req_ready=0, alu_oe=1, operands held stable. Counter increments each cycle. On the cycle the counter reaches SETTLE_CYCLES-1, at that edge: capture alu_d into rsp_data, set rsp_cmd, rsp_err=0, rsp_valid=1, alu_oe=0, go to RESP.
  - RESP: rsp_valid=1; rsp_data, rsp_cmd and rsp_err held stable until rsp_valid&&rsp_ready. Then rsp_valid=0 and go to IDLE. alu_oe=0 throughout.
- Latency:
  - Normal op: rsp_valid rises SETTLE_CYCLES+1 cycles after acceptance.
  - Div-by-zero: rsp_valid rises 1 cycle after acceptance.
- Throughput: one op in flight. A new request is accepted no earlier than the cycle after the response handshake.
- Capture rule: alu_d is sampled only while alu_oe=1. Z/X on alu_d at other times is ignored and never propagates.
- Operand outputs keep their last values in IDLE and RESP. They change only on acceptance or reset.
- Result width: RES_W bits captured unchanged. No sign extension; no truncation checking.
- Unknown opcode: every 4-bit value is legal and forwarded.

Optional Feature:
- Macro ALU_OPCOUNT_EN.
- With it: extra outputs op_count[15:0] and err_count[7:0].
  - op_count increments on each response handshake.
  - err_count increments on each handshake with rsp_err=1.
  - Both saturate at all-ones and reset to 0.
- Without it: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- alu_pkg holds:
  - the 16 opcode localparams (ADD=0, INC, SUB, DEC, MUL, DIV=5, SHL, SHR, AND=8, OR, INV, NAND, NOR, XOR, XNOR, BUF=15);
  - the default widths DATA_W/RES_W;
  - the state encoding (IDLE, SETTLE, RESP).
- No sub-module: the FSM, settle counter and response register stay in one module.

Test Plan:
- ADD, a=8'hF0, b=8'h20, ALU model attached, SETTLE_CYCLES=1 -> alu_oe=1 in cycle T+1 only; rsp_valid at T+2 with rsp_data=16'h0110, rsp_err=0.
- MUL, a=8'hFF, b=8'hFF -> rsp_data=16'hFE01, rsp_cmd=4'h4.
- DIV, a=8'h40, b=8'h00 -> alu_oe never asserts; rsp_valid at T+1 with rsp_data=16'hFFFF, rsp_err=1.
- SUB, a=8'h10, b=8'h03, rsp_ready held low 5 cycles -> rsp_data=16'h000D stable, req_ready=0, alu_oe=0 throughout; new request accepted the cycle after the handshake.
- SETTLE_CYCLES=3, rst_n low during the second SETTLE cycle -> next edge gives alu_oe=0, rsp_valid=0, req_ready=1; no response emitted.
- With ALU_OPCOUNT_EN: 3 normal ops and 1 div-by-zero -> op_count=4, err_count=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, default widths and FSM state encoding for the ALU command driver.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] INC  = 4'd1;
    localparam logic [3:0] SUB  = 4'd2;
    localparam logic [3:0] DEC  = 4'd3;
    localparam logic [3:0] MUL  = 4'd4;
    localparam logic [3:0] DIV  = 4'd5;
    localparam logic [3:0] SHL  = 4'd6;
    localparam logic [3:0] SHR  = 4'd7;
    localparam logic [3:0] AND  = 4'd8;
    localparam logic [3:0] OR   = 4'd9;
    localparam logic [3:0] INV  = 4'd10;
    localparam logic [3:0] NAND = 4'd11;
    localparam logic [3:0] NOR  = 4'd12;
    localparam logic [3:0] XOR  = 4'd13;
    localparam logic [3:0] XNOR = 4'd14;
    localparam logic [3:0] BUF  = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Drives one op at a time into the combinational ALU, waits SETTLE_CYCLES, captures the result.
// Optional ALU_OPCOUNT_EN adds saturating op_count/err_count outputs.
module alu_cmd_driver #(
    parameter int DATA_W        = alu_pkg::DATA_W,
    parameter int RES_W         = alu_pkg::RES_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [3:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_oe,
    input  logic [RES_W-1:0]  alu_d,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic [3:0]        rsp_cmd,
    output logic              rsp_err
`ifdef ALU_OPCOUNT_EN
    ,
    output logic [15:0]       op_count,
    output logic [7:0]        err_count
`endif
);
    import alu_pkg::*;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [RES_W-1:0]  rdata_q, rdata_d;
    logic [3:0]        rcmd_q, rcmd_d;
    logic              rerr_q, rerr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        b_d     = b_q;
        rdata_d = rdata_q;
        rcmd_d  = rcmd_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d = req_cmd;
                    a_d   = req_a;
                    b_d   = req_b;
                    cnt_d = '0;
                    // Divide-by-zero is answered locally; the ALU is never enabled.
                    if (req_cmd == DIV && req_b == '0) begin
                        rdata_d = '1;
                        rcmd_d  = req_cmd;
                        rerr_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // alu_d is only ever sampled here, so Z/X outside SETTLE never reaches rsp_data.
                if (cnt_q == SETTLE_LAST) begin
                    rdata_d = alu_d;
                    rcmd_d  = cmd_q;
                    rerr_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rdata_q <= '0;
            rcmd_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rdata_q <= rdata_d;
            rcmd_q  <= rcmd_d;
            rerr_q  <= rerr_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign alu_oe    = (state_q == SETTLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_cmd   = cmd_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_data  = rdata_q;
    assign rsp_cmd   = rcmd_q;
    assign rsp_err   = rerr_q;

`ifdef ALU_OPCOUNT_EN
    logic [15:0] opc_q, opc_d;
    logic [7:0]  errc_q, errc_d;
    logic        fire;

    assign fire = (state_q == RESP) && rsp_ready;

    always_comb begin
        opc_d  = opc_q;
        errc_d = errc_q;
        if (fire && opc_q != '1)            opc_d  = opc_q + 16'd1;
        if (fire && rerr_q && errc_q != '1) errc_d = errc_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opc_q  <= '0;
            errc_q <= '0;
        end else begin
            opc_q  <= opc_d;
            errc_q <= errc_d;
        end
    end

    assign op_count  = opc_q;
    assign err_count = errc_q;
`else
    // Op/error counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench: transaction-level model checked every cycle on u0 (SETTLE=1), directed checks on u1 (SETTLE=3).
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] x, y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (c)
            4'd0:    return x + y;
            4'd1:    return x + 16'd1;
            4'd2:    return x - y;
            4'd3:    return x - 16'd1;
            4'd4:    return x * y;
            4'd5:    return (b == 8'h00) ? 16'hFFFF : x / y;
            4'd6:    return x << 1;
            4'd7:    return x >> 1;
            4'd8:    return x & y;
            4'd9:    return x | y;
            4'd10:   return {8'h00, ~a};
            4'd11:   return {8'h00, ~(a & b)};
            4'd12:   return {8'h00, ~(a | b)};
            4'd13:   return {8'h00, a ^ b};
            4'd14:   return {8'h00, ~(a ^ b)};
            default: return x;
        endcase
    endfunction

    // ---------------- u0: SETTLE_CYCLES=1 ----------------
    logic        rst_n0, req_valid0, req_ready0, alu_oe0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [3:0]  req_cmd0, alu_cmd0, rsp_cmd0;
    logic [7:0]  req_a0, req_b0, alu_a0, alu_b0;
    logic [15:0] rsp_data0;
    wire  [15:0] alu_d0;
    assign alu_d0 = alu_oe0 ? alu_fn(alu_cmd0, alu_a0, alu_b0) : 16'hzzzz;
`ifdef ALU_OPCOUNT_EN
    logic [15:0] op_count0, op_count1;
    logic [7:0]  err_count0, err_count1;
`endif

    alu_cmd_driver #(.DATA_W(8), .RES_W(16), .SETTLE_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n0),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_cmd(req_cmd0),
        .req_a(req_a0), .req_b(req_b0),
        .alu_cmd(alu_cmd0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_oe(alu_oe0), .alu_d(alu_d0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
        .rsp_cmd(rsp_cmd0), .rsp_err(rsp_err0)
`ifdef ALU_OPCOUNT_EN
        , .op_count(op_count0), .err_count(err_count0)
`endif
    );

    // ---------------- u1: SETTLE_CYCLES=3 ----------------
    logic        rst_n1, req_valid1, req_ready1, alu_oe1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [3:0]  req_cmd1, alu_cmd1, rsp_cmd1;
    logic [7:0]  req_a1, req_b1, alu_a1, alu_b1;
    logic [15:0] rsp_data1;
    wire  [15:0] alu_d1;
    assign alu_d1 = alu_oe1 ? alu_fn(alu_cmd1, alu_a1, alu_b1) : 16'hzzzz;

    alu_cmd_driver #(.DATA_W(8), .RES_W(16), .SETTLE_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_cmd(req_cmd1),
        .req_a(req_a1), .req_b(req_b1),
        .alu_cmd(alu_cmd1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_oe(alu_oe1), .alu_d(alu_d1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_cmd(rsp_cmd1), .rsp_err(rsp_err1)
`ifdef ALU_OPCOUNT_EN
        , .op_count(op_count1), .err_count(err_count1)
`endif
    );

    // ---------------- transaction model for u0 ----------------
    // One pending op, timed by edges since acceptance: enable for S cycles, then response.
    localparam int S0 = 1;
    int unsigned edge_n = 0;
    int unsigned m_acc = 0;
    bit          m_pend = 1'b0, m_div0 = 1'b0;
    logic [3:0]  m_cmd = '0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [15:0] m_res = '0;
    int          m_ops = 0, m_errs = 0;

    function automatic bit m_valid();
        int unsigned k;
        k = edge_n - m_acc;
        return m_pend && (k >= (m_div0 ? 0 : S0));
    endfunction

    function automatic bit m_oe();
        int unsigned k;
        k = edge_n - m_acc;
        return m_pend && !m_div0 && (k < S0);
    endfunction

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (!rst_n0) begin
            m_pend <= 1'b0;
            m_cmd  <= '0;
            m_a    <= '0;
            m_b    <= '0;
        end else if (m_pend) begin
            if (m_valid() && rsp_ready0) begin
                m_pend <= 1'b0;
                m_ops  <= m_ops + 1;
                if (m_div0) m_errs <= m_errs + 1;
            end
        end else if (req_valid0) begin
            m_pend <= 1'b1;
            m_acc  <= edge_n + 1;
            m_div0 <= (req_cmd0 == 4'd5) && (req_b0 == 8'h00);
            m_cmd  <= req_cmd0;
            m_a    <= req_a0;
            m_b    <= req_b0;
            m_res  <= alu_fn(req_cmd0, req_a0, req_b0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req_ready", {31'd0, req_ready0}, {31'd0, !m_pend});
            chk("m_alu_oe",    {31'd0, alu_oe0},    {31'd0, m_oe()});
            chk("m_rsp_valid", {31'd0, rsp_valid0}, {31'd0, m_valid()});
            chk("m_alu_cmd",   {28'd0, alu_cmd0},   {28'd0, m_cmd});
            chk("m_alu_a",     {24'd0, alu_a0},     {24'd0, m_a});
            chk("m_alu_b",     {24'd0, alu_b0},     {24'd0, m_b});
            if (m_valid()) begin
                chk("m_rsp_data", {16'd0, rsp_data0}, {16'd0, m_res});
                chk("m_rsp_cmd",  {28'd0, rsp_cmd0},  {28'd0, m_cmd});
                chk("m_rsp_err",  {31'd0, rsp_err0},  {31'd0, m_div0});
            end
        end
    end

    task automatic send0(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (req_ready0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send0_timeout", 32'd0, 32'd1);
        req_valid0 = 1'b1;
        req_cmd0   = c;
        req_a0     = a;
        req_b0     = b;
        @(posedge clk);
        #1 req_valid0 = 1'b0;
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        req_valid0 = 1'b0; req_cmd0 = '0; req_a0 = '0; req_b0 = '0; rsp_ready0 = 1'b1;
        req_valid1 = 1'b0; req_cmd1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst_n0 = 1'b1; rst_n1 = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready0}, 32'd1);
        chk("rst_alu_oe",    {31'd0, alu_oe0},    32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err0},   32'd0);
        chk("rst_rsp_data",  {16'd0, rsp_data0},  32'd0);
        chk("rst_alu_a",     {24'd0, alu_a0},     32'd0);

        // ADD F0+20, single-cycle enable then response
        send0(4'd0, 8'hF0, 8'h20);
        @(negedge clk);
        chk("add_oe_t1",    {31'd0, alu_oe0},    32'd1);
        chk("add_vld_t1",   {31'd0, rsp_valid0}, 32'd0);
        @(negedge clk);
        chk("add_oe_t2",    {31'd0, alu_oe0},    32'd0);
        chk("add_vld_t2",   {31'd0, rsp_valid0}, 32'd1);
        chk("add_data",     {16'd0, rsp_data0},  32'h0110);
        chk("add_err",      {31'd0, rsp_err0},   32'd0);

        // MUL FF*FF
        @(negedge clk);
        send0(4'd4, 8'hFF, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        chk("mul_data", {16'd0, rsp_data0}, 32'hFE01);
        chk("mul_cmd",  {28'd0, rsp_cmd0},  32'h4);

        // DIV by zero: answered next cycle, enable never raised
        @(negedge clk);
        send0(4'd5, 8'h40, 8'h00);
        @(negedge clk);
        chk("div0_oe",   {31'd0, alu_oe0},    32'd0);
        chk("div0_vld",  {31'd0, rsp_valid0}, 32'd1);
        chk("div0_data", {16'd0, rsp_data0},  32'hFFFF);
        chk("div0_err",  {31'd0, rsp_err0},   32'd1);
        @(posedge clk);

        // SUB with response back-pressure for 5 cycles
        #1 rsp_ready0 = 1'b0;
        send0(4'd2, 8'h10, 8'h03);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sub_vld",   {31'd0, rsp_valid0}, 32'd1);
            chk("sub_data",  {16'd0, rsp_data0},  32'h000D);
            chk("sub_ready", {31'd0, req_ready0}, 32'd0);
            chk("sub_oe",    {31'd0, alu_oe0},    32'd0);
        end
        rsp_ready0 = 1'b1;
        req_valid0 = 1'b1; req_cmd0 = 4'd13; req_a0 = 8'h5A; req_b0 = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        chk("hs_ready",     {31'd0, req_ready0}, 32'd1);
        chk("hs_vld",       {31'd0, rsp_valid0}, 32'd0);
        chk("hs_cmd_hold",  {28'd0, alu_cmd0},   32'd2);
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        @(negedge clk);
        chk("xor_cmd", {28'd0, alu_cmd0}, 32'd13);
        chk("xor_oe",  {31'd0, alu_oe0},  32'd1);
        @(negedge clk);
        chk("xor_data", {16'd0, rsp_data0}, 32'h0055);

        // u1 normal op: three enable cycles, response on the fourth
        @(negedge clk);
        req_valid1 = 1'b1; req_cmd1 = 4'd0; req_a1 = 8'h01; req_b1 = 8'h02;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_oe",  {31'd0, alu_oe1},    32'd1);
            chk("s3_vld", {31'd0, rsp_valid1}, 32'd0);
        end
        @(negedge clk);
        chk("s3_vld_rise", {31'd0, rsp_valid1}, 32'd1);
        chk("s3_data",     {16'd0, rsp_data1},  32'h0003);
        chk("s3_oe_off",   {31'd0, alu_oe1},    32'd0);
        @(posedge clk);

        // u1 reset during the second settle cycle drops the op
        #1 req_valid1 = 1'b1; req_cmd1 = 4'd4; req_a1 = 8'h03; req_b1 = 8'h03;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        chk("mid_oe_s1", {31'd0, alu_oe1}, 32'd1);
        @(negedge clk);
        rst_n1 = 1'b0;
        @(posedge clk);
        #1 rst_n1 = 1'b1;
        @(negedge clk);
        chk("mid_rst_oe",    {31'd0, alu_oe1},    32'd0);
        chk("mid_rst_vld",   {31'd0, rsp_valid1}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready1}, 32'd1);
        chk("mid_rst_a",     {24'd0, alu_a1},     32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", {31'd0, rsp_valid1}, 32'd0);
        end

`ifdef ALU_OPCOUNT_EN
        chk("op_count",       {16'd0, op_count0},  m_ops);
        chk("err_count",      {24'd0, err_count0}, m_errs);
        chk("op_count_lit",   {16'd0, op_count0},  32'd5);
        chk("err_count_lit",  {24'd0, err_count0}, 32'd1);
        chk("op_count1_lit",  {16'd0, op_count1},  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
